// File: rtl/vu_window_level.sv
// vu_window_level: per-window bit-density meter for the VU chain.
// Samples the upstream free-running count once per WIN-cycle window, turns the
// wrap-safe delta into a 0..LEDS level, and drives a thermometer bar plus a
// peak-hold marker that holds for HOLD_WINDOWS updates and then decays one
// step per window.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_PRIME | first window after reset; capture baseline count, no update
// S_RUN   | every window end: capture count, update level/bar/peak
module vu_window_level #(
  parameter  int W            = 8,
  parameter  int WIN          = 200,
  parameter  int LEDS         = 8,
  parameter  int HOLD_WINDOWS = 4,
  localparam int LW           = $clog2(LEDS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    count_in,
  output logic [LW-1:0]   level,
  output logic [LEDS-1:0] bar,
  output logic [LEDS-1:0] peak,
  output logic            win_valid
);

  localparam int CW = $clog2(WIN);
  localparam int HW = $clog2(HOLD_WINDOWS + 2);
  localparam int PW = W + LW;

  typedef enum logic {S_PRIME, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_win_cnt;
  logic            w_win_end;
  logic            w_update;
  logic [W-1:0]    r_prev;
  logic [W-1:0]    w_d;
  logic [W-1:0]    w_dsat;
  logic [PW-1:0]   w_prod;
  logic [LW-1:0]   w_lvl;
  logic [LEDS-1:0] w_bar;
  logic [LW-1:0]   r_peak_level;
  logic [LW-1:0]   w_pk_nxt;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_nxt;
  logic [LEDS-1:0] w_peak_oh;

  assign w_win_end = (r_win_cnt == CW'(WIN - 1));

  // Free-running window counter, 0..WIN-1.
  always_ff @(posedge clk) begin
    if (rst)            r_win_cnt <= '0;
    else if (w_win_end) r_win_cnt <= '0;
    else                r_win_cnt <= r_win_cnt + CW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_PRIME;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; an update is only allowed once a baseline exists.
  always_comb begin
    w_state_nxt = r_state;
    w_update    = 1'b0;
    case (r_state)
      S_PRIME: if (w_win_end) w_state_nxt = S_RUN;
      S_RUN:   if (w_win_end) w_update = 1'b1;
      default: w_state_nxt = S_PRIME;
    endcase
  end

  // Baseline count, refreshed at every window end in either state.
  always_ff @(posedge clk) begin
    if (rst)            r_prev <= '0;
    else if (w_win_end) r_prev <= count_in;
  end

  // Delta is modulo 2^W; anything above WIN means the upstream jumped, so clamp.
  assign w_d    = count_in - r_prev;
  assign w_dsat = (w_d > W'(WIN)) ? W'(WIN) : w_d;
  assign w_prod = PW'(w_dsat) * PW'(LEDS);

  // Level = number of thresholds k*WIN met by d*LEDS; thresholds are monotonic.
  always_comb begin
    w_lvl = '0;
    for (int k = 1; k <= LEDS; k++) begin
      if (w_prod >= PW'(k * WIN)) w_lvl = LW'(k);
    end
  end

  // Thermometer code of the new level.
  always_comb begin
    w_bar = '0;
    for (int i = 0; i < LEDS; i++) w_bar[i] = (w_lvl > LW'(i));
  end

  // Peak hold/decay evaluated against the new level.
  always_comb begin
    w_pk_nxt   = r_peak_level;
    w_hold_nxt = r_hold_cnt;
    if (w_lvl >= r_peak_level) begin
      w_pk_nxt   = w_lvl;
      w_hold_nxt = HW'(HOLD_WINDOWS);
    end else if (r_hold_cnt != '0) begin
      w_hold_nxt = r_hold_cnt - HW'(1);
    end else begin
      // peak_level > level here, so the decrement cannot underflow
      w_pk_nxt = ((r_peak_level - LW'(1)) > w_lvl) ? (r_peak_level - LW'(1)) : w_lvl;
    end
  end

  // One-hot marker for the next peak level; zero peak lights nothing.
  always_comb begin
    w_peak_oh = '0;
    for (int i = 0; i < LEDS; i++) w_peak_oh[i] = (w_pk_nxt == LW'(i + 1));
  end

  // Output registers, loaded only on a RUN window end.
  always_ff @(posedge clk) begin
    if (rst) begin
      level        <= '0;
      bar          <= '0;
      peak         <= '0;
      r_peak_level <= '0;
      r_hold_cnt   <= '0;
      win_valid    <= 1'b0;
    end else begin
      win_valid <= w_update;
      if (w_update) begin
        level        <= w_lvl;
        bar          <= w_bar;
        peak         <= w_peak_oh;
        r_peak_level <= w_pk_nxt;
        r_hold_cnt   <= w_hold_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vu_window_level.sv
// Directed bench for vu_window_level with default parameters.
module tb_vu_window_level;

  localparam int WIN = 200;

  logic       clk;
  logic       rst;
  logic [7:0] count_in;
  logic [3:0] level;
  logic [7:0] bar;
  logic [7:0] peak;
  logic       win_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] pk_exp [12] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h40, 8'h20,
                              8'h10, 8'h08, 8'h04, 8'h02, 8'h02, 8'h02};

  vu_window_level dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .level     (level),
    .bar       (bar),
    .peak      (peak),
    .win_valid (win_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next update pulse; sampled 1 time unit after the edge.
  task automatic wait_upd(input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < WIN + 5; n++) begin
      @(posedge clk);
      #1;
      if (win_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(ok), 32'd1);
  endtask

  // Present a new count for the next window end and check the resulting update.
  task automatic step(input string tag, input logic [7:0] cin, input logic [3:0] el,
                      input logic [7:0] eb, input logic [7:0] ep);
    count_in = cin;
    wait_upd(tag);
    chk({tag, "_level"}, 32'(level), 32'(el));
    chk({tag, "_bar"},   32'(bar),   32'(eb));
    chk({tag, "_peak"},  32'(peak),  32'(ep));
  endtask

  // Count cycles from reset release to the first pulse.
  task automatic first_pulse(input string tag, input bit incr);
    int first;
    first = 0;
    for (int n = 1; n <= 2 * WIN + 10; n++) begin
      @(posedge clk);
      #1;
      if (incr) count_in = count_in + 8'd1;
      if (win_valid) begin
        first = n;
        break;
      end
    end
    chk({tag, "_first_valid_cycle"}, 32'(first), 32'd400);
  endtask

  initial begin
    logic [7:0] c;
    rst      = 1'b1;
    count_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_bar",   32'(bar),   32'd0);
    chk("rst_peak",  32'(peak),  32'd0);
    chk("rst_valid", 32'(win_valid), 32'd0);
    rst = 1'b0;

    // Count increments every clock: d = 200 at the first RUN window end.
    first_pulse("inc", 1'b1);
    chk("inc_level", 32'(level), 32'd8);
    chk("inc_bar",   32'(bar),   32'hFF);
    chk("inc_peak",  32'(peak),  32'h80);
    @(posedge clk);
    #1;
    chk("pulse_width", 32'(win_valid), 32'd0);

    // Baseline is now 143 (399 mod 256).
    step("d100",    8'd243, 4'd4, 8'h0F, 8'h80);
    step("d24",     8'd11,  4'd0, 8'h00, 8'h80);
    step("d25",     8'd36,  4'd1, 8'h01, 8'h80);
    step("sat230",  8'd10,  4'd8, 8'hFF, 8'h80);
    step("sat240",  8'd250, 4'd8, 8'hFF, 8'h80);
    step("wrap100", 8'd94,  4'd4, 8'h0F, 8'h80);

    // Peak hold and decay: one window at level 8, then level 2 windows.
    step("pk_cap",  8'd38,  4'd8, 8'hFF, 8'h80);
    c = 8'd38;
    for (int i = 0; i < 12; i++) begin
      c = c + 8'd50;
      step($sformatf("pk%0d", i), c, 4'd2, 8'h03, pk_exp[i]);
    end

    // Mid-window reset while the bar is full.
    c = c + 8'd200;
    step("pre_rst", c, 4'd8, 8'hFF, 8'h80);
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_bar",   32'(bar),   32'd0);
    chk("mid_rst_peak",  32'(peak),  32'd0);
    chk("mid_rst_valid", 32'(win_valid), 32'd0);
    rst = 1'b0;

    // Count held constant, so the first post-reset update shows d = 0.
    first_pulse("post_rst", 1'b0);
    chk("post_rst_level", 32'(level), 32'd0);
    chk("post_rst_bar",   32'(bar),   32'd0);
    chk("post_rst_peak",  32'(peak),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
